mm_register_master: RTL and testbench

// - Avalon-MM master: issues single register read/write transactions to MM slaves (e.g. the MAC-address register bank).
// - Takes commands from a local control source (CPU bridge / test sequencer) and returns one response per command.
// - Honours mm_waitrequest and mm_readdatavalid; a timeout guards against a stalled slave.

---
 rtl/mm_register_master.sv | 137 +++++++++++++
 tb/tb_mm_register_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mm_register_master.sv
// Avalon-MM register master: turns single local commands into one MM read or write
// and returns exactly one response per command, with a timeout for stalled slaves.
module mm_register_master #(
    parameter int unsigned ADDRESS_SIZE   = 8,
    parameter int unsigned REG_SIZE       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS_SIZE-1:0] cmd_address,
    input  logic [REG_SIZE-1:0]     cmd_writedata,
    output logic                    rsp_valid,
    output logic [REG_SIZE-1:0]     rsp_readdata,
    output logic                    rsp_error,
    output logic [ADDRESS_SIZE-1:0] mm_address,
    output logic [REG_SIZE-1:0]     mm_writedata,
    output logic                    mm_write,
    output logic                    mm_read,
    input  logic [REG_SIZE-1:0]     mm_readdata,
    input  logic                    mm_readdatavalid,
    input  logic                    mm_waitrequest
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [ADDRESS_SIZE-1:0] address_nx;
    logic [REG_SIZE-1:0]     writedata_nx, readdata_nx;
    logic                    write_nx, read_nx, rsp_valid_nx, rsp_error_nx;
    logic                    timeout_c;

    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign cmd_ready = (state == IDLE);

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        address_nx   = mm_address;
        writedata_nx = mm_writedata;
        write_nx     = mm_write;
        read_nx      = mm_read;
        rsp_valid_nx = 1'b0;
        readdata_nx  = rsp_readdata;
        rsp_error_nx = rsp_error;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    address_nx   = cmd_address;
                    writedata_nx = cmd_writedata;
                    write_nx     = cmd_write;
                    read_nx      = !cmd_write;
                    cnt_nx       = '0;
                    state_nx     = REQ;
                end
            end
            REQ: begin
                if (!mm_waitrequest) begin
                    write_nx = 1'b0;
                    read_nx  = 1'b0;
                    if (mm_write) begin
                        readdata_nx  = '0;
                        rsp_error_nx = 1'b0;
                        rsp_valid_nx = 1'b1;
                        state_nx     = RESP;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = WAIT_RD;
                    end
                end else if (timeout_c) begin
                    write_nx     = 1'b0;
                    read_nx      = 1'b0;
                    readdata_nx  = {REG_SIZE{1'b1}};
                    rsp_error_nx = 1'b1;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WAIT_RD: begin
                if (mm_readdatavalid) begin
                    readdata_nx  = mm_readdata;
                    rsp_error_nx = 1'b0;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end else if (timeout_c) begin
                    readdata_nx  = {REG_SIZE{1'b1}};
                    rsp_error_nx = 1'b1;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears request lines immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mm_address   <= '0;
            mm_writedata <= '0;
            mm_write     <= 1'b0;
            mm_read      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_readdata <= '0;
            rsp_error    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            mm_address   <= address_nx;
            mm_writedata <= writedata_nx;
            mm_write     <= write_nx;
            mm_read      <= read_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_readdata <= readdata_nx;
            rsp_error    <= rsp_error_nx;
        end
    end

endmodule

// File: tb/tb_mm_register_master.sv
// Directed bench for mm_register_master with a small register-bank slave model
// (TIMEOUT_CYCLES=4 so timeout paths are short).
module tb_mm_register_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_readdata;
    logic [7:0]  mm_address;
    logic [31:0] mm_writedata, mm_readdata;
    logic        mm_write, mm_read, mm_readdatavalid, mm_waitrequest;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    mm_register_master #(.ADDRESS_SIZE(8), .REG_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
        .mm_address(mm_address), .mm_writedata(mm_writedata),
        .mm_write(mm_write), .mm_read(mm_read),
        .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
        .mm_waitrequest(mm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_mm_write"},  32'(mm_write), 32'd0);
        check({tag, "_mm_read"},   32'(mm_read), 32'd0);
        check({tag, "_mm_addr"},   32'(mm_address), 32'd0);
        check({tag, "_mm_wdata"},  mm_writedata, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_readdata, 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    endtask

    // Issues one command (accept edge = cycle 0) and plays the slave: waitrequest for the
    // first 'waits' request cycles, readdatavalid 'rdv_dly' cycles after acceptance (<0: never).
    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input int waits, input int rdv_dly,
                           output int rsp_cyc, output int rsp_cnt, output int req_cyc,
                           output logic [31:0] rdata, output logic err, output logic hold_ok);
        int acc;
        acc = -1; rsp_cyc = -1; rsp_cnt = 0; req_cyc = 0;
        rdata = '0; err = 1'b0; hold_ok = 1'b1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_writedata = d;
        mm_waitrequest = (waits > 0); mm_readdatavalid = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc; rdata = rsp_readdata; err = rsp_error;
                end
            end
            mm_waitrequest = 1'b0;
            mm_readdatavalid = 1'b0;
            mm_readdata = 32'h0BAD_0BAD;
            if (rsp_cyc >= 0 && cyc > rsp_cyc) break;
            if (mm_write || mm_read) begin
                req_cyc++;
                if (mm_address != a || mm_write != wr || mm_read != !wr || cmd_ready ||
                    (wr && mm_writedata != d)) hold_ok = 1'b0;
                if (req_cyc <= waits) mm_waitrequest = 1'b1;
                else if (acc < 0) begin
                    acc = cyc;
                    if (wr) mem[a] = d;
                end
            end else if (rsp_cyc < 0 && cmd_ready) begin
                hold_ok = 1'b0;
            end
            if (!wr && acc >= 0 && rdv_dly >= 0 && cyc == acc + rdv_dly) begin
                mm_readdatavalid = 1'b1;
                mm_readdata = mem[a];
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic txn(input string tag, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input int waits, input int rdv_dly, input int exp_rsp, input int exp_req,
                       input logic [31:0] exp_data, input logic exp_err);
        int rc, rn, rq;
        logic [31:0] rd;
        logic er, ho;
        run_cmd(wr, a, d, waits, rdv_dly, rc, rn, rq, rd, er, ho);
        check({tag, "_rsp_cycle"}, rc, exp_rsp);
        check({tag, "_rsp_count"}, rn, 32'd1);
        check({tag, "_req_cycles"}, rq, exp_req);
        check({tag, "_rdata"}, rd, exp_data);
        check({tag, "_error"}, 32'(er), 32'(exp_err));
        check({tag, "_hold"}, 32'(ho), 32'd1);
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int rsp_seen;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'h1357_9BDF;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_writedata = '0;
        mm_readdata = '0; mm_readdatavalid = 1'b0; mm_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        txn("wr_zero_wait", 1'b1, 8'h01, 32'h0000_1234, 0, -1, 2, 1, 32'h0, 1'b0);
        txn("rd_rdv1",      1'b0, 8'h02, 32'h0,         0,  1, 3, 1, 32'hDEAD_BEEF, 1'b0);
        txn("wr_wait3",     1'b1, 8'h05, 32'hA5A5_5A5A, 3, -1, 5, 4, 32'h0, 1'b0);
        txn("rd_timeout",   1'b0, 8'h03, 32'h0,         0, -1, 7, 1, 32'hFFFF_FFFF, 1'b1);
        txn("wr_req_to",    1'b1, 8'h07, 32'h7777_0007, 99, -1, 6, 5, 32'hFFFF_FFFF, 1'b1);
        txn("wr_acc_on_to", 1'b1, 8'h08, 32'h8888_0008, 4, -1, 6, 5, 32'h0, 1'b0);
        txn("rd_rdv_on_to", 1'b0, 8'h03, 32'h0,         0,  5, 7, 1, 32'h1357_9BDF, 1'b0);
        txn("rd_rdv_accyc", 1'b0, 8'h02, 32'h0,         0,  0, 7, 1, 32'hFFFF_FFFF, 1'b1);

        // Reset while waiting for read data.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h02; mm_waitrequest = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("rstw_mm_read_req", 32'(mm_read), 32'd1);
        @(posedge clk); #1;
        check("rstw_in_wait_rd", {30'd0, cmd_ready, mm_read}, 32'd0);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_wait_rd");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset while a read is stalled by waitrequest: request must drop without a clock.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h09; mm_waitrequest = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("rstq_mm_read_req", 32'(mm_read), 32'd1);
        #2 rst = 1'b1;
        #1 check("rstq_mm_read_drop", 32'(mm_read), 32'd0);
        check("rstq_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mm_waitrequest = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            mm_readdatavalid = (i == 2);
            @(posedge clk); #1;
            if (rsp_valid) rsp_seen++;
        end
        mm_readdatavalid = 1'b0;
        check("rst_no_rsp", rsp_seen, 32'd0);

        // Back-to-back write then read of the same MAC-address register.
        txn("b2b_wr", 1'b1, 8'h10, 32'hCAFE_0010, 0, -1, 2, 1, 32'h0, 1'b0);
        txn("b2b_rd", 1'b0, 8'h10, 32'h0,         0,  1, 3, 1, 32'hCAFE_0010, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
